// File: rtl/alu_pkg.sv
// =============================================================================
// alu_pkg : shared widths, ALU function codes and issue-controller states
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

package alu_pkg;

  localparam int REG_DATA_WIDTH_DEF    = 16;
  localparam int ALU_CONTROL_WIDTH_DEF = 4;

  localparam logic [3:0] ADD = 4'b1111;
  localparam logic [3:0] SUB = 4'b1110;
  localparam logic [3:0] AND = 4'b1101;
  localparam logic [3:0] OR  = 4'b1100;
  localparam logic [3:0] MUL = 4'b0001;
  localparam logic [3:0] DIV = 4'b0010;
  localparam logic [3:0] SLL = 4'b1010;
  localparam logic [3:0] SLR = 4'b1011;
  localparam logic [3:0] ROL = 4'b1001;
  localparam logic [3:0] ROR = 4'b1000;
  localparam logic [3:0] NOP = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// =============================================================================
// alu_issue_ctrl_if : request, ALU-port and response bundle of alu_issue_ctrl
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

interface alu_issue_ctrl_if #(
  parameter int REG_DATA_WIDTH    = 16,
  parameter int ALU_CONTROL_WIDTH = 4
);
  logic                         req_valid;
  logic                         req_ready;
  logic [REG_DATA_WIDTH-1:0]    req_a;
  logic [REG_DATA_WIDTH-1:0]    req_b;
  logic [ALU_CONTROL_WIDTH-1:0] req_op;
  logic [REG_DATA_WIDTH-1:0]    alu_a;
  logic [REG_DATA_WIDTH-1:0]    alu_b;
  logic [ALU_CONTROL_WIDTH-1:0] alu_control;
  logic [REG_DATA_WIDTH-1:0]    alu_r;
  logic [REG_DATA_WIDTH-1:0]    alu_s;
  logic                         alu_exc;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [REG_DATA_WIDTH-1:0]    rsp_r;
  logic [REG_DATA_WIDTH-1:0]    rsp_s;
  logic                         rsp_exc;
  logic                         busy;

  // Issue-controller side
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_r, alu_s, alu_exc, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_r, rsp_s,
           rsp_exc, busy
  );

  // Control unit / ALU / consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, alu_r, alu_s, alu_exc, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_r, rsp_s,
           rsp_exc, busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// =============================================================================
// alu_issue_ctrl : registers ALU operands, waits SETTLE_CYCLES, captures result
// Optional: ALU_STICKY_EXC_EN adds exc_clr / exc_sticky
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int REG_DATA_WIDTH    = REG_DATA_WIDTH_DEF,
  parameter int ALU_CONTROL_WIDTH = ALU_CONTROL_WIDTH_DEF,
  parameter int SETTLE_CYCLES     = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef ALU_STICKY_EXC_EN
  input  logic exc_clr,
  output logic exc_sticky,
`endif
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  issue_state_e                 state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [REG_DATA_WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [REG_DATA_WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [ALU_CONTROL_WIDTH-1:0] alu_control_q, alu_control_d;
  logic [REG_DATA_WIDTH-1:0]    rsp_r_q, rsp_r_d;
  logic [REG_DATA_WIDTH-1:0]    rsp_s_q, rsp_s_d;
  logic                         rsp_exc_q, rsp_exc_d;

  logic div_by_zero;
  logic rsp_hs;

  assign div_by_zero = (bus.req_op == ALU_CONTROL_WIDTH'(DIV)) && (bus.req_b == '0);
  assign rsp_hs      = (state_q == RESP) && bus.rsp_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    rsp_r_d       = rsp_r_q;
    rsp_s_d       = rsp_s_q;
    rsp_exc_d     = rsp_exc_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (div_by_zero) begin
            // Answer locally; the ALU is never driven with this request.
            rsp_r_d   = '0;
            rsp_s_d   = '0;
            rsp_exc_d = 1'b1;
            state_d   = RESP;
          end else begin
            alu_a_d       = bus.req_a;
            alu_b_d       = bus.req_b;
            alu_control_d = bus.req_op;
            cnt_d         = CNT_LOAD;
            state_d       = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          rsp_r_d   = bus.alu_r;
          rsp_s_d   = bus.alu_s;
          rsp_exc_d = bus.alu_exc;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          alu_control_d = ALU_CONTROL_WIDTH'(NOP);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      rsp_r_q       <= '0;
      rsp_s_q       <= '0;
      rsp_exc_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      rsp_r_q       <= rsp_r_d;
      rsp_s_q       <= rsp_s_d;
      rsp_exc_q     <= rsp_exc_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_control_q;
  assign bus.rsp_r       = rsp_r_q;
  assign bus.rsp_s       = rsp_s_q;
  assign bus.rsp_exc     = rsp_exc_q;

`ifdef ALU_STICKY_EXC_EN
  logic exc_sticky_q, exc_sticky_d;

  // Set takes priority over a simultaneous clear.
  always_comb begin
    exc_sticky_d = exc_sticky_q;
    if (rsp_hs && rsp_exc_q) begin
      exc_sticky_d = 1'b1;
    end else if (exc_clr) begin
      exc_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exc_sticky_q <= 1'b0;
    end else begin
      exc_sticky_q <= exc_sticky_d;
    end
  end

  assign exc_sticky = exc_sticky_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// =============================================================================
// tb_alu_issue_ctrl : directed vector bench with a behavioural ALU model
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_alu_issue_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] s;
    logic        exc;
  } alu_res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r;
    logic [15:0] exp_s;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.REG_DATA_WIDTH(16), .ALU_CONTROL_WIDTH(4)) if1 ();
  alu_issue_ctrl_if #(.REG_DATA_WIDTH(16), .ALU_CONTROL_WIDTH(4)) if3 ();

`ifdef ALU_STICKY_EXC_EN
  logic exc_clr1, exc_sticky1, exc_clr3, exc_sticky3;
`endif

  alu_issue_ctrl #(.REG_DATA_WIDTH(16), .ALU_CONTROL_WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst1),
`ifdef ALU_STICKY_EXC_EN
    .exc_clr    (exc_clr1),
    .exc_sticky (exc_sticky1),
`endif
    .bus        (if1.slave)
  );

  alu_issue_ctrl #(.REG_DATA_WIDTH(16), .ALU_CONTROL_WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst        (rst3),
`ifdef ALU_STICKY_EXC_EN
    .exc_clr    (exc_clr3),
    .exc_sticky (exc_sticky3),
`endif
    .bus        (if3.slave)
  );

  function automatic alu_res_t alu_model(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    alu_res_t    res;
    logic [31:0] p;
    logic [15:0] t;
    res = '0;
    case (op)
      ADD: begin
        t = a + b;
        res.r = t;
        res.exc = (a[15] == b[15]) && (t[15] != a[15]);
      end
      SUB: begin
        t = a - b;
        res.r = t;
        res.exc = (a[15] != b[15]) && (t[15] != a[15]);
      end
      AND: res.r = a & b;
      OR:  res.r = a | b;
      MUL: begin
        p = a * b;
        res.r = p[15:0];
        res.s = p[31:16];
      end
      DIV: begin
        if (b == 16'd0) res.exc = 1'b1;
        else begin
          res.r = a / b;
          res.s = a % b;
        end
      end
      SLL: res.r = a << b[3:0];
      SLR: res.r = a >> b[3:0];
      NOP: res = '0;
      default: res.exc = 1'b1;
    endcase
    return res;
  endfunction

  alu_res_t m1, m3;
  assign m1 = alu_model(if1.alu_control, if1.alu_a, if1.alu_b);
  assign m3 = alu_model(if3.alu_control, if3.alu_a, if3.alu_b);
  assign if1.alu_r = m1.r;
  assign if1.alu_s = m1.s;
  assign if1.alu_exc = m1.exc;
  assign if3.alu_r = m3.r;
  assign if3.alu_s = m3.s;
  assign if3.alu_exc = m3.exc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full transaction on the SETTLE_CYCLES=1 instance; called just after a negedge.
  task automatic do_op(input int idx, input vec_t v);
    int lat;
    if1.req_valid = 1'b1;
    if1.req_op    = v.op;
    if1.req_a     = v.a;
    if1.req_b     = v.b;
    chk($sformatf("v%0d_req_ready", idx), 32'(if1.req_ready), 32'd1);
    @(negedge clk);
    if1.req_valid = 1'b0;
    lat = 1;
    while (!if1.rsp_valid && lat < 20) begin
      if (lat == 1) begin
        chk($sformatf("v%0d_drv_ctl", idx), 32'(if1.alu_control), 32'(v.op));
        chk($sformatf("v%0d_drv_a", idx), 32'(if1.alu_a), 32'(v.a));
      end
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_rsp_r", idx), 32'(if1.rsp_r), 32'(v.exp_r));
    chk($sformatf("v%0d_rsp_s", idx), 32'(if1.rsp_s), 32'(v.exp_s));
    chk($sformatf("v%0d_rsp_exc", idx), 32'(if1.rsp_exc), 32'(v.exp_exc));
    if (v.exp_lat == 1)
      chk($sformatf("v%0d_div0_ctl", idx), 32'(if1.alu_control), 32'd0);
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk($sformatf("v%0d_post_valid", idx), 32'(if1.rsp_valid), 32'd0);
    chk($sformatf("v%0d_post_ctl", idx), 32'(if1.alu_control), 32'd0);
    chk($sformatf("v%0d_post_ready", idx), 32'(if1.req_ready), 32'd1);
`ifdef ALU_STICKY_EXC_EN
    chk($sformatf("v%0d_sticky", idx), 32'(exc_sticky1), 32'(v.exp_exc));
    exc_clr1 = 1'b1;
    @(negedge clk);
    exc_clr1 = 1'b0;
    chk($sformatf("v%0d_sticky_clr", idx), 32'(exc_sticky1), 32'd0);
`endif
  endtask

  vec_t vecs[7];
  vec_t ovf;

  initial begin
    int lat3;
    logic seen;
    vecs[0] = '{ADD,     16'd3,      16'd4,      16'd7,      16'd0,      1'b0, 2};
    vecs[1] = '{ADD,     16'h7FFF,   16'h0001,   16'h8000,   16'h0000,   1'b1, 2};
    vecs[2] = '{MUL,     16'h0100,   16'h0100,   16'h0000,   16'h0001,   1'b0, 2};
    vecs[3] = '{DIV,     16'd7,      16'd2,      16'd3,      16'd1,      1'b0, 2};
    vecs[4] = '{DIV,     16'd9,      16'd0,      16'd0,      16'd0,      1'b1, 1};
    vecs[5] = '{SUB,     16'd5,      16'd7,      16'hFFFE,   16'd0,      1'b0, 2};
    vecs[6] = '{4'b0011, 16'd1,      16'd2,      16'd0,      16'd0,      1'b1, 2};

    rst1 = 1'b0; rst3 = 1'b0;
    if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_op = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_a = '0; if3.req_b = '0; if3.req_op = '0; if3.rsp_ready = 1'b0;
`ifdef ALU_STICKY_EXC_EN
    exc_clr1 = 1'b0; exc_clr3 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
    chk("rst_alu_ctl", 32'(if1.alu_control), 32'd0);
    chk("rst_alu_a", 32'(if1.alu_a), 32'd0);
    chk("rst_rsp_r", 32'(if1.rsp_r), 32'd0);
    chk("rst_rsp_exc", 32'(if1.rsp_exc), 32'd0);
    chk("rst_req_ready", 32'(if1.req_ready), 32'd1);
    rst1 = 1'b1; rst3 = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_op(i, vecs[i]);

    // Overflow response handshaken while clear is held: the set must win.
`ifdef ALU_STICKY_EXC_EN
    exc_clr1 = 1'b1;
`endif
    ovf = vecs[1];
    do_op(10, ovf);

    // Backpressure with a competing request pending.
    if1.req_valid = 1'b1; if1.req_op = ADD; if1.req_a = 16'd3; if1.req_b = 16'd4;
    @(negedge clk);
    if1.req_op = ADD; if1.req_a = 16'd1; if1.req_b = 16'd1;
    @(negedge clk);
    chk("bp_valid_rise", 32'(if1.rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_r", k), 32'(if1.rsp_r), 32'd7);
      chk($sformatf("bp_hold%0d_ready", k), 32'(if1.req_ready), 32'd0);
      chk($sformatf("bp_hold%0d_valid", k), 32'(if1.rsp_valid), 32'd1);
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk("bp_back_idle", 32'(if1.req_ready), 32'd1);
    @(negedge clk);
    if1.req_valid = 1'b0;
    chk("bp_new_ctl", 32'(if1.alu_control), 32'(ADD));
    chk("bp_new_a", 32'(if1.alu_a), 32'd1);
    @(negedge clk);
    chk("bp_new_valid", 32'(if1.rsp_valid), 32'd1);
    chk("bp_new_r", 32'(if1.rsp_r), 32'd2);
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;

    // SETTLE_CYCLES=3: latency of SETTLE_CYCLES+1.
    if3.req_valid = 1'b1; if3.req_op = MUL; if3.req_a = 16'd6; if3.req_b = 16'd7;
    @(negedge clk);
    if3.req_valid = 1'b0;
    lat3 = 1;
    while (!if3.rsp_valid && lat3 < 20) begin
      @(negedge clk);
      lat3++;
    end
    chk("s3_latency", 32'(lat3), 32'd4);
    chk("s3_rsp_r", 32'(if3.rsp_r), 32'd42);
    if3.rsp_ready = 1'b1;
    @(negedge clk);
    if3.rsp_ready = 1'b0;

    // Reset during DRIVE abandons the operation.
    if3.req_valid = 1'b1; if3.req_op = ADD; if3.req_a = 16'd2; if3.req_b = 16'd3;
    @(negedge clk);
    if3.req_valid = 1'b0;
    chk("s3_drive_busy", 32'(if3.busy), 32'd1);
    chk("s3_drive_ctl", 32'(if3.alu_control), 32'(ADD));
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    chk("s3_rst_busy", 32'(if3.busy), 32'd0);
    chk("s3_rst_valid", 32'(if3.rsp_valid), 32'd0);
    chk("s3_rst_ctl", 32'(if3.alu_control), 32'd0);
    chk("s3_rst_ready", 32'(if3.req_ready), 32'd1);
    if3.rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | if3.rsp_valid | if3.busy;
    end
    if3.rsp_ready = 1'b0;
    chk("s3_no_late_rsp", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator that sits between the control unit and the combinational ALU.
- Accepts one operation request per transaction over a valid/ready handshake.
- Drives the ALU operand and function-code inputs from registers, waits a fixed settle time, then captures the ALU's low result, high result and exception outputs.
- Returns the captured values on a valid/ready response channel.
- The ALU is instantiated by the parent; this block only connects to its ports.

Parameters:
REG_DATA_WIDTH, 16, width of operands and of each result half
ALU_CONTROL_WIDTH, 4, width of the ALU function code
SETTLE_CYCLES, 1, cycles (>=1) the ALU inputs are held stable before capture

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset: synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid is also high
req_a  in  REG_DATA_WIDTH  operand a
req_b  in  REG_DATA_WIDTH  operand b
req_op  in  ALU_CONTROL_WIDTH  function code
alu_a  out  REG_DATA_WIDTH  to ALU operand a (registered)
alu_b  out  REG_DATA_WIDTH  to ALU operand b (registered)
alu_control  out  ALU_CONTROL_WIDTH  to ALU function code (registered)
alu_r  in  REG_DATA_WIDTH  from ALU, low result / quotient
alu_s  in  REG_DATA_WIDTH  from ALU, high result / remainder
alu_exc  in  1  from ALU, overflow or invalid-code flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_r  out  REG_DATA_WIDTH  captured low result
rsp_s  out  REG_DATA_WIDTH  captured high result
rsp_exc  out  1  captured exception
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (rst low at a clock edge) forces all of the following:
- State = IDLE, settle counter = 0.
- alu_a = alu_b = 0 and alu_control = 0, which is the ALU NOP code.
- rsp_valid = 0, rsp_r = rsp_s = 0, rsp_exc = 0, busy = 0.
- Reset mid-transaction abandons the operation; no response is produced.

States:
- IDLE: req_ready = 1. On req_valid, latch req_a, req_b and req_op into alu_a, alu_b and alu_control, load the counter with SETTLE_CYCLES-1, and go to DRIVE.
- DRIVE: req_ready = 0 and the ALU inputs are held. When the counter reaches 0, capture alu_r, alu_s and alu_exc into rsp_r, rsp_s and rsp_exc, and go to RESP. Otherwise decrement the counter.
- RESP: rsp_valid = 1, with rsp_* held stable until the rsp_valid && rsp_ready handshake completes. On handshake, clear rsp_valid, return alu_control to 0 (alu_a and alu_b keep their values), and go to IDLE.

Timing:
- Latency from request acceptance to rsp_valid is SETTLE_CYCLES+1 cycles.
- Throughput is one operation per SETTLE_CYCLES+2 cycles, with no back-to-back acceptance.
- rsp_ready high in the same cycle that rsp_valid rises completes the handshake in that cycle.

Divide by zero:
- If req_op = DIV and req_b = 0, skip DRIVE and go directly from IDLE to RESP on the next edge.
- The response is rsp_r = rsp_s = 0, rsp_exc = 1.
- alu_control stays 0, so the ALU never sees the request.

Other rules:
- Invalid function codes are passed through to the ALU unchanged; the ALU's exception flag is reported as captured.
- req_* are ignored outside IDLE.
- Responses never drop while the consumer applies backpressure.

Optional Feature:
ALU_STICKY_EXC_EN
- Defined: adds input exc_clr (1 bit) and output exc_sticky (1 bit).
  - exc_sticky sets when a response with rsp_exc = 1 is handshaken.
  - It clears on exc_clr, or on reset to 0.
  - If set and clear happen in the same cycle, set wins.
- Not defined: neither port exists, and there is no additional state.

Decomposition:
Package alu_pkg holds:
- the REG_DATA_WIDTH and ALU_CONTROL_WIDTH defaults;
- the function-code constants ADD=1111, SUB=1110, AND=1101, OR=1100, MUL=0001, DIV=0010, SLL=1010, SLR=1011, ROL=1001, ROR=1000, NOP=0000;
- the state encoding (IDLE, DRIVE, RESP).

No sub-module is required; the settle counter and FSM are implemented inline.

Test Plan:
- ADD, a=3, b=4, SETTLE_CYCLES=1 -> rsp_valid at cycle 2 after acceptance; rsp_r=7, rsp_s=0, rsp_exc=0.
- ADD, a=0x7FFF, b=0x0001 -> rsp_r=0x8000, rsp_exc=1; with ALU_STICKY_EXC_EN, exc_sticky=1 after handshake and clears after exc_clr.
- MUL, a=0x0100, b=0x0100 -> rsp_r=0x0000, rsp_s=0x0001. DIV, a=7, b=2 -> rsp_r=3, rsp_s=1.
- DIV, a=9, b=0 -> rsp_valid 1 cycle after acceptance; rsp_r=0, rsp_s=0, rsp_exc=1; alu_control never leaves 0.
- rsp_ready held low 5 cycles during RESP with a new req_valid pending -> rsp_* stable, req_ready=0; the new request is accepted only after handshake and return to IDLE.
- rst low during DRIVE with SETTLE_CYCLES=3 -> next cycle: IDLE, busy=0, rsp_valid=0, alu_control=0; no response appears afterwards.
